// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers per-bit and group propagate/generate; stage 2 resolves carries and registers results.

module one_bit_carry_look_ahead (
  input  logic a,
  input  logic b,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
endmodule

module cla_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             c0;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_g;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_c0;
  logic [NGRP-1:0]  s1_gp;
  logic [NGRP-1:0]  s1_gg;

  logic             s1_ready;
  logic             s2_ready;
  logic [NGRP:0]    grp_c;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign b_op = sub ? ~in1 : in1;
  assign c0   = sub | cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    one_bit_carry_look_ahead u_cell (
      .a (in0[i]),
      .b (b_op[i]),
      .p (p[i]),
      .g (g[i])
    );
  end

  // Group P/G folded from the group LSB upward: G = g[k+n] | p[k+n] & G_lower.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < int'(NGRP); j++) begin
      grp_p[j] = 1'b1;
      for (int i = 0; i < int'(GROUP); i++) begin
        grp_g[j] = g[j*int'(GROUP)+i] | (p[j*int'(GROUP)+i] & grp_g[j]);
        grp_p[j] = grp_p[j] & p[j*int'(GROUP)+i];
      end
    end
  end

  assign s2_ready = !out_valid | out_ready;
  assign s1_ready = !s1_valid | s2_ready;
  assign in_ready = s1_ready;

  // Stage 1: propagate/generate capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_c0    <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p;
        s1_g  <= g;
        s1_c0 <= c0;
        s1_gp <= grp_p;
        s1_gg <= grp_g;
      end
    end
  end

  // Group carries across groups, then intra-group carries seeded by each group carry-in.
  always_comb begin
    grp_c    = '0;
    c        = '0;
    grp_c[0] = s1_c0;
    for (int j = 0; j < int'(NGRP); j++) begin
      grp_c[j+1] = s1_gg[j] | (s1_gp[j] & grp_c[j]);
    end
    for (int j = 0; j < int'(NGRP); j++) begin
      c[j*int'(GROUP)] = grp_c[j];
      for (int i = 0; i < int'(GROUP) - 1; i++) begin
        c[j*int'(GROUP)+i+1] = s1_g[j*int'(GROUP)+i] | (s1_p[j*int'(GROUP)+i] & c[j*int'(GROUP)+i]);
      end
    end
    c[WIDTH] = grp_c[NGRP];
    sum      = s1_p ^ c[WIDTH-1:0];
  end

  // Stage 2: result and flag registers; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out  <= sum;
        cout <= c[WIDTH];
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
        zero <= ~|sum;
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: reset, arithmetic corner cases, backpressure, full-rate stream.

module tb_cla_pipe_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         cout;
  logic         ovf;
  logic         zero;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Beat tables and expected {ovf,cout,zero,out} per beat.
  logic [W-1:0] va [128];
  logic [W-1:0] vb [128];
  logic         vci[128];
  logic         vsb[128];
  logic [34:0]  vexp[128];

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide add of the formed operands; overflow from operand/result sign bits.
  function automatic logic [34:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic         o;
    bb = sb ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb | ci)};
    o  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {o, s[W], (s[W-1:0] == '0), s[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single beat into an empty pipe; checks exact 2-cycle latency and the result.
  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input logic [34:0] exp);
    in0 = a; in1 = b; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check(tag, 64'({ovf, cout, zero, out}), 64'(exp));
    step();
  endtask

  // Streams n table beats; out_ready held low for the first 'stall' cycles.
  task automatic stream(input int n, input int stall, output int pops,
                        output int first_pop, output int last_pop, output int acc_at_drop);
    int idx;
    idx = 0; pops = 0; first_pop = -1; last_pop = -1; acc_at_drop = -1;
    for (int cyc = 0; cyc < n + stall + 12; cyc++) begin
      in_valid  = (idx < n);
      in0       = va[idx % 128];
      in1       = vb[idx % 128];
      cin       = vci[idx % 128];
      sub       = vsb[idx % 128];
      out_ready = (cyc >= stall);
      #1;
      if (in_valid && !in_ready && acc_at_drop < 0) acc_at_drop = idx;
      if (out_valid && !out_ready && pops < n)
        check("hold", 64'({ovf, cout, zero, out}), 64'(vexp[pops]));
      if (out_valid && out_ready) begin
        if (pops < n) check("stream_out", 64'({ovf, cout, zero, out}), 64'(vexp[pops]));
        else check("stream_extra", 64'(1), 64'(0));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int pops, fp, lp, drop, seen;
    rst_n = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    step();
    check("reset_outs", 64'({out_valid, ovf, cout, zero, out}), 64'(0));
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    step();

    // Reset with two beats in flight.
    in0 = 32'd3; in1 = 32'd4; in_valid = 1'b1;
    step();
    in0 = 32'd10; in1 = 32'd20;
    step();
    in_valid = 1'b0;
    check("pre_reset_out", 64'({out_valid, out}), 64'({1'b1, 32'd7}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({out_valid, out}), 64'(0));
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) seen++;
      step();
    end
    check("no_stale_beat", 64'(seen), 64'(0));
    check("ready_after_reset", 64'(in_ready), 64'(1));

    // Arithmetic corners: {ovf,cout,zero,out}.
    single("ripple",   32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, {3'b011, 32'h0000_0000});
    single("sovf",     32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {3'b100, 32'h8000_0000});
    single("sub_brw",  32'd5,         32'd7, 1'b0, 1'b1, {3'b000, 32'hFFFF_FFFE});
    single("cin_only", 32'd0,         32'd0, 1'b1, 1'b0, {3'b000, 32'h0000_0001});
    single("sub_zero", 32'd0,         32'd0, 1'b0, 1'b1, {3'b011, 32'h0000_0000});

    // Backpressure: 1+1..4+4 with 3 stalled cycles.
    for (int i = 0; i < 4; i++) begin
      va[i] = 32'(i + 1); vb[i] = 32'(i + 1); vci[i] = 1'b0; vsb[i] = 1'b0;
    end
    vexp[0] = {3'b000, 32'd2};
    vexp[1] = {3'b000, 32'd4};
    vexp[2] = {3'b000, 32'd6};
    vexp[3] = {3'b000, 32'd8};
    stream(4, 3, pops, fp, lp, drop);
    check("bp_count", 64'(pops), 64'(4));
    check("bp_ready_drop", 64'(drop), 64'(2));

    // Full-rate random stream.
    for (int i = 0; i < 100; i++) begin
      va[i] = $urandom; vb[i] = $urandom;
      vci[i] = 1'($urandom_range(0, 1)); vsb[i] = 1'($urandom_range(0, 1));
      vexp[i] = model(va[i], vb[i], vci[i], vsb[i]);
    end
    stream(100, 0, pops, fp, lp, drop);
    check("tp_count", 64'(pops), 64'(100));
    check("tp_first", 64'(fp), 64'(2));
    check("tp_span", 64'(lp - fp), 64'(99));
    check("tp_no_drop", 64'(drop), 64'(-1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
